fetch_queue: RTL and testbench

Instruction fetch stage for the single-cycle MIPS core. Owns the fetch program counter, reads the combinational instruction ROM one word per cycle, and buffers fetched words with their byte addresses in a small prefetch queue. Decode consumes them through a valid/ready handshake. A redirect input flushes the queue and restarts fetch, giving branch and jump logic a clean restart point.

---
 rtl/fetch_queue.sv | 100 ++++++++++
 tb/tb_fetch_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, reads the instruction ROM and buffers {word, pc} pairs.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 12
) (
    input  logic                       clk,
    input  logic                       areset,
    output logic [ADDR_W-1:0]          im_addr,
    output logic                       im_req,
    input  logic [31:0]                im_data,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                inst,
    output logic [ADDR_W-1:0]          inst_pc,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [31:0]       word_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic full;
    logic empty;
    logic fetch;
    logic push;
    logic pop;

    always_comb begin
        full  = (count == CNT_W'(DEPTH));
        empty = (count == '0);
        fetch = !areset && !redirect && !full;
        pop   = !empty && inst_ready && !redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
        // An empty queue forwards the ROM word directly; it is only stored if decode stalls.
        push       = fetch && !(empty && inst_ready);
        inst_valid = !empty || fetch;
        inst       = empty ? im_data  : word_mem[head];
        inst_pc    = empty ? fetch_pc : pc_mem[head];
        if (empty && !fetch) begin
            inst    = word_mem[head];
            inst_pc = pc_mem[head];
        end
`else
        push       = fetch;
        inst_valid = !empty;
        inst       = word_mem[head];
        inst_pc    = pc_mem[head];
`endif
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            fetch_pc <= ADDR_W'(RESET_PC);
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                word_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~ADDR_W'(3);
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (fetch) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (push) begin
                word_mem[tail] <= im_data;
                pc_mem[tail]   <= fetch_pc;
                tail           <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign im_addr = fetch_pc;
    assign im_req  = fetch;
    assign q_count = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a reference queue of fetched PCs is pushed on each predicted
// fetch and popped on each predicted handshake; every cycle the DUT outputs are compared to it.
module tb_fetch_queue;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;
    localparam int RST_PC = 12;

    logic              clk;
    logic              areset;
    logic [ADDR_W-1:0] im_addr;
    logic              im_req;
    logic [31:0]       im_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic [2:0]        q_count;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] sb_q [$];
    logic [ADDR_W-1:0] m_pc;
    logic              m_rst;

    fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .areset(areset), .im_addr(im_addr), .im_req(im_req), .im_data(im_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .q_count(q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
        return 32'hA000_0000 + 32'(a >> 2);
    endfunction

    always_comb im_data = rom_word(im_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare outputs at the falling edge, then advance the reference at the rising edge.
    task automatic step();
        logic              m_req;
        logic              e_valid;
        logic              byp;
        logic [ADDR_W-1:0] e_pc;
        @(negedge clk);
        m_req = !areset && !redirect && (sb_q.size() < DEPTH);
        byp   = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = m_req && (sb_q.size() == 0);
`endif
        e_valid = (sb_q.size() != 0) || byp;
        e_pc    = (sb_q.size() != 0) ? sb_q[0] : m_pc;
        check("im_req", 32'(im_req), 32'(m_req));
        check("im_addr", 32'(im_addr), 32'(m_pc));
        check("q_count", 32'(q_count), 32'(sb_q.size()));
        check("inst_valid", 32'(inst_valid), 32'(e_valid));
        if (e_valid) begin
            check("inst_pc", 32'(inst_pc), 32'(e_pc));
            check("inst", inst, rom_word(e_pc));
        end
        if (m_rst && areset) begin
            check("rst_inst", inst, 32'h0);
            check("rst_inst_pc", 32'(inst_pc), 32'h0);
        end
        @(posedge clk);
        m_rst = areset;
        if (areset) begin
            sb_q.delete();
            m_pc = ADDR_W'(RST_PC);
        end else if (redirect) begin
            sb_q.delete();
            m_pc = redirect_pc & ~ADDR_W'(3);
        end else begin
            if (sb_q.size() != 0 && inst_ready) void'(sb_q.pop_front());
            if (m_req && !(byp && inst_ready)) sb_q.push_back(m_pc);
            if (m_req) m_pc = m_pc + ADDR_W'(4);
        end
        #1;
    endtask

    initial begin
        areset      = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b1;
        m_pc        = ADDR_W'(RST_PC);
        m_rst       = 1'b1;
        @(posedge clk);
        #1;

        // Reset start: second reset cycle, then streaming with decode always ready.
        step();
        check("rst_addr", 32'(im_addr), 32'd12);
        check("rst_count", 32'(q_count), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        areset = 1'b0;
        step();
`ifndef FETCH_QUEUE_BYPASS_EN
        check("first_inst_pc", 32'(inst_pc), 32'd12);
        check("first_inst", inst, 32'hA000_0003);
`endif
        repeat (7) step();

        // Stall fill from reset.
        areset = 1'b1;
        step();
        step();
        areset     = 1'b0;
        inst_ready = 1'b0;
        repeat (4) step();
        check("fill_count", 32'(q_count), 32'd4);
        check("fill_req", 32'(im_req), 32'd0);
        check("fill_head", inst, 32'hA000_0003);
        step();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("pop_count", 32'(q_count), 32'd3);
        step();
        check("refill_count", 32'(q_count), 32'd4);

        // Redirect flush with three entries queued.
        inst_ready = 1'b1;
        step();
        inst_ready  = 1'b0;
        check("pre_redir_count", 32'(q_count), 32'd3);
        redirect    = 1'b1;
        redirect_pc = ADDR_W'(6);
        step();
        redirect = 1'b0;
        check("redir_count", 32'(q_count), 32'd0);
        check("redir_addr", 32'(im_addr), 32'd4);
`ifndef FETCH_QUEUE_BYPASS_EN
        check("redir_valid", 32'(inst_valid), 32'd0);
`endif
        step();
        check("redir_head_valid", 32'(inst_valid), 32'd1);
        check("redir_head_pc", 32'(inst_pc), 32'd4);

        // Redirect together with a ready consumer and a valid head.
        step();
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = ADDR_W'(8);
        step();
        redirect   = 1'b0;
        inst_ready = 1'b0;
        check("redir_rdy_count", 32'(q_count), 32'd0);
        check("redir_rdy_addr", 32'(im_addr), 32'd8);

        // Reset while full and redirecting.
        repeat (5) step();
        check("full_before_rst", 32'(q_count), 32'd4);
        areset      = 1'b1;
        redirect    = 1'b1;
        redirect_pc = ADDR_W'(4);
        step();
        check("mid_rst_addr", 32'(im_addr), 32'd12);
        check("mid_rst_count", 32'(q_count), 32'd0);
        check("mid_rst_valid", 32'(inst_valid), 32'd0);
        check("mid_rst_inst", inst, 32'h0);
        check("mid_rst_pc", 32'(inst_pc), 32'h0);
        step();
        areset   = 1'b0;
        redirect = 1'b0;

        // Mixed traffic: random decode stalls and occasional redirects.
        for (int i = 0; i < 60; i++) begin
            inst_ready  = 1'($urandom_range(0, 1));
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = ADDR_W'($urandom_range(0, 15));
            step();
        end
        redirect = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
